// File: rtl/seq_detector_param_if.sv
// Serial pattern detector bus: qualified input bit stream plus the match
// pulse, match counter and overflow flag coming back out.
// Optional macro SEQDET_CLR_EN adds the synchronous counter clear signal clr.
interface seq_detector_param_if #(
    parameter int CNT_W = 3
);
    logic             data;
    logic             data_vld;
    logic             match;
    logic [CNT_W-1:0] out;
    logic             ovf;
`ifdef SEQDET_CLR_EN
    logic             clr;

    modport master (output data, data_vld, clr, input match, out, ovf);
    modport slave  (input data, data_vld, clr, output match, out, ovf);
`else
    modport master (output data, data_vld, input match, out, ovf);
    modport slave  (input data, data_vld, output match, out, ovf);
`endif
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with match counter.
// Shifts in one bit per data_vld cycle, pulses match (one cycle after the
// completing bit) whenever the last PATTERN_W accepted bits equal PATTERN,
// and counts matches with optional saturation and a sticky overflow flag.
// Optional macro SEQDET_CLR_EN: adds the clr input, which zeroes out/ovf
// without touching detection state.
module seq_detector_param #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1010,
    parameter int                   OVERLAP   = 1,
    parameter int                   CNT_W     = 3,
    parameter int                   SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_detector_param_if.slave  bus
);
    // Fill counter must be able to hold PATTERN_W itself.
    localparam int               FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PATTERN_W-1:0] sreg_q, sreg_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic                 match_q, match_d;
    logic [CNT_W-1:0]     out_q, out_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     out_base;
    logic                 ovf_base;
    logic                 hit;

    // Next-state: shift/fill on valid bits, detect, then clear-then-count.
    always_comb begin
        sreg_d   = sreg_q;
        fill_d   = fill_q;
        hit      = 1'b0;
        out_base = out_q;
        ovf_base = ovf_q;

        if (bus.data_vld) begin
            sreg_d = {sreg_q[PATTERN_W-2:0], bus.data};
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
            // fill gating keeps reset zeros from ever counting as pattern bits
            hit = (fill_d == FILL_FULL) && (sreg_d == PATTERN);
            // Non-overlapping search: the next match needs a full fresh window
            if (hit && (OVERLAP == 0)) begin
                fill_d = '0;
            end
        end

`ifdef SEQDET_CLR_EN
        // Clear takes effect first so a coincident match counts from zero
        if (bus.clr) begin
            out_base = '0;
            ovf_base = 1'b0;
        end
`endif

        out_d   = out_base;
        ovf_d   = ovf_base;
        match_d = hit;
        if (hit) begin
            if (out_base == CNT_MAX) begin
                ovf_d = 1'b1;
                out_d = (SATURATE != 0) ? CNT_MAX : '0;
            end else begin
                out_d = out_base + CNT_W'(1);
            end
        end
    end

    // State and registered outputs; reset aborts any partial pattern.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.match = match_q;
    assign bus.out   = out_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: five differently-configured instances share
// one stimulus stream; a bit-history model predicts every output each cycle
// and directed streams pin the model with hand-computed literals.
module tb_seq_detector_param;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic data = 1'b0;
    logic data_vld = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    seq_detector_param_if #(.CNT_W(3)) bus0 ();
    seq_detector_param_if #(.CNT_W(3)) bus1 ();
    seq_detector_param_if #(.CNT_W(2)) bus2 ();
    seq_detector_param_if #(.CNT_W(2)) bus3 ();
    seq_detector_param_if #(.CNT_W(3)) bus4 ();

    assign bus0.data = data;  assign bus0.data_vld = data_vld;
    assign bus1.data = data;  assign bus1.data_vld = data_vld;
    assign bus2.data = data;  assign bus2.data_vld = data_vld;
    assign bus3.data = data;  assign bus3.data_vld = data_vld;
    assign bus4.data = data;  assign bus4.data_vld = data_vld;
`ifdef SEQDET_CLR_EN
    assign bus0.clr = clr;
    assign bus1.clr = clr;
    assign bus2.clr = clr;
    assign bus3.clr = clr;
    assign bus4.clr = clr;
`endif

    // d0: 101 overlap; d1: 101 non-overlap; d2/d3: 2-bit counter sat/wrap; d4: defaults
    seq_detector_param #(.PATTERN_W(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(3), .SATURATE(1))
        u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    seq_detector_param #(.PATTERN_W(3), .PATTERN(3'b101), .OVERLAP(0), .CNT_W(3), .SATURATE(1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    seq_detector_param #(.PATTERN_W(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(2), .SATURATE(1))
        u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    seq_detector_param #(.PATTERN_W(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(2), .SATURATE(0))
        u3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    seq_detector_param #(.PATTERN_W(4), .PATTERN(4'b1010), .OVERLAP(1), .CNT_W(3), .SATURATE(1))
        u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    // Model configuration, one entry per instance
    int pw[N]  = '{3, 3, 3, 3, 4};
    int pat[N] = '{5, 5, 5, 5, 10};
    int ovl[N] = '{1, 0, 1, 1, 1};
    int cw[N]  = '{3, 3, 2, 2, 3};
    int sat[N] = '{1, 1, 1, 0, 1};

    // Model state: bits accepted since last restart, expected outputs
    int hist[N];
    int nbits[N];
    int exp_match[N];
    int exp_out[N];
    int exp_ovf[N];
    bit mvalid = 1'b0;

    int act_m[N];
    int act_o[N];
    int act_v[N];
    int pulses[N];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Negedge: compare outputs from the last edge, then predict the next edge
    always @(negedge clk) begin
        act_m[0] = int'(bus0.match); act_o[0] = int'(bus0.out); act_v[0] = int'(bus0.ovf);
        act_m[1] = int'(bus1.match); act_o[1] = int'(bus1.out); act_v[1] = int'(bus1.ovf);
        act_m[2] = int'(bus2.match); act_o[2] = int'(bus2.out); act_v[2] = int'(bus2.ovf);
        act_m[3] = int'(bus3.match); act_o[3] = int'(bus3.out); act_v[3] = int'(bus3.ovf);
        act_m[4] = int'(bus4.match); act_o[4] = int'(bus4.out); act_v[4] = int'(bus4.ovf);
        if (mvalid) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("cyc d%0d match", i), act_m[i], exp_match[i]);
                check($sformatf("cyc d%0d out", i), act_o[i], exp_out[i]);
                check($sformatf("cyc d%0d ovf", i), act_v[i], exp_ovf[i]);
                if (act_m[i] == 1) pulses[i]++;
            end
        end
        for (int i = 0; i < N; i++) begin
            int maxv;
            maxv = (1 << cw[i]) - 1;
            if (!rst_n) begin
                hist[i] = 0; nbits[i] = 0;
                exp_match[i] = 0; exp_out[i] = 0; exp_ovf[i] = 0;
            end else begin
                exp_match[i] = 0;
`ifdef SEQDET_CLR_EN
                if (clr) begin
                    exp_out[i] = 0;
                    exp_ovf[i] = 0;
                end
`endif
                if (data_vld) begin
                    hist[i] = ((hist[i] << 1) | int'(data)) & 32'hFFFF;
                    nbits[i]++;
                    if (nbits[i] >= pw[i] && (hist[i] & ((1 << pw[i]) - 1)) == pat[i]) begin
                        exp_match[i] = 1;
                        if (ovl[i] == 0) nbits[i] = 0;
                    end
                end
                if (exp_match[i] == 1) begin
                    if (exp_out[i] == maxv) begin
                        exp_ovf[i] = 1;
                        exp_out[i] = (sat[i] != 0) ? maxv : 0;
                    end else begin
                        exp_out[i] = exp_out[i] + 1;
                    end
                end
            end
        end
        if (!rst_n) mvalid = 1'b1;
    end

    task automatic tick(input logic b, input logic v);
        @(posedge clk); #1;
        data = b; data_vld = v; clr = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; data_vld = 1'b0; clr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) pulses[i] = 0;
    endtask

    // Send a bit string (MSB-first as written), with gap idle cycles after each bit
    task automatic send_str(input string s, input int gap);
        for (int k = 0; k < s.len(); k++) begin
            tick(s[k] == "1", 1'b1);
            repeat (gap) tick(1'b0, 1'b0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        do_reset();

        // Test 1: reset mid-stream aborts a partial pattern and clears count
        send_str("101", 0);
        send_str("10", 0);
        @(posedge clk); #1;
        rst_n = 1'b0; data = 1'b1; data_vld = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("t1 d0 out after reset", int'(bus0.out), 0);
        check("t1 d0 match after reset", int'(bus0.match), 0);
        for (int i = 0; i < N; i++) pulses[i] = 0;
        data = 1'b0; data_vld = 1'b1;
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        check("t1 d0 pulses straddle", pulses[0], 0);
        $display("t1 reset mid-stream: d0 out=%0d", bus0.out);

        // Tests 2/3: 1,0,1,0,1 overlapping vs non-overlapping
        do_reset();
        send_str("10101", 0);
        tick(1'b0, 1'b0);
        check("t2 d0 out", int'(bus0.out), 2);
        check("t3 d1 out", int'(bus1.out), 1);
        tick(1'b0, 1'b0);
        check("t2 d0 pulses", pulses[0], 2);
        check("t3 d1 pulses", pulses[1], 1);
        $display("t2/t3 stream 10101: d0 out=%0d d1 out=%0d", bus0.out, bus1.out);

        // Test 4: 1,0,0,1,0,1,0,1 contiguous and with 3-cycle gaps
        do_reset();
        send_str("10010101", 0);
        tick(1'b0, 1'b0);
        check("t4 d0 out", int'(bus0.out), 2);
        check("t4 d1 out", int'(bus1.out), 1);
        do_reset();
        send_str("10010101", 3);
        tick(1'b0, 1'b0);
        check("t4 gap d0 out", int'(bus0.out), 2);
        check("t4 gap d0 pulses", pulses[0], 2);
        $display("t4 stream 10010101 gapped: d0 out=%0d", bus0.out);

        // Test 5: five overlapping matches into a 2-bit counter
        do_reset();
        send_str("1010101", 0);
        tick(1'b0, 1'b0);
        check("t5 d3 out after 3", int'(bus3.out), 3);
        check("t5 d3 ovf after 3", int'(bus3.ovf), 0);
        send_str("01", 0);
        tick(1'b0, 1'b0);
        check("t5 d3 out after 4", int'(bus3.out), 0);
        check("t5 d3 ovf after 4", int'(bus3.ovf), 1);
        check("t5 d2 ovf after 4", int'(bus2.ovf), 1);
        send_str("01", 0);
        tick(1'b0, 1'b0);
        check("t5 d2 out", int'(bus2.out), 3);
        check("t5 d3 out", int'(bus3.out), 1);
        check("t5 d0 out", int'(bus0.out), 5);
        check("t5 d4 out", int'(bus4.out), 4);
        check("t5 d4 ovf", int'(bus4.ovf), 0);
        do_reset();
        check("t5 d2 ovf after reset", int'(bus2.ovf), 0);
        $display("t5 saturate/wrap: done");

`ifdef SEQDET_CLR_EN
        // Test 6: clear coincident with a completing bit
        do_reset();
        send_str("101010101", 0);
        tick(1'b0, 1'b1);
        check("t6 d2 out before clr", int'(bus2.out), 3);
        check("t6 d2 ovf before clr", int'(bus2.ovf), 1);
        @(posedge clk); #1;
        data = 1'b1; data_vld = 1'b1; clr = 1'b1;
        tick(1'b0, 1'b0);
        check("t6 d2 out", int'(bus2.out), 1);
        check("t6 d2 ovf", int'(bus2.ovf), 0);
        check("t6 d2 match", int'(bus2.match), 1);
        $display("t6 clr with match: d2 out=%0d", bus2.out);
`endif

        // Random stream checked against the model every cycle
        do_reset();
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            data = 1'($urandom_range(0, 1));
            data_vld = ($urandom_range(0, 3) != 0);
            clr = 1'b0;
`ifdef SEQDET_CLR_EN
            clr = ($urandom_range(0, 19) == 0);
`endif
            rst_n = ($urandom_range(0, 59) != 0);
        end
        tick(1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("random stream: 400 cycles");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
